// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared geometry, timing, state and sound definitions for the pong engine
package pong_pkg;

    localparam int SCREENWIDTH  = 640;
    localparam int SCREENHEIGHT = 480;
    localparam int PADDLEWIDTH  = 10;
    localparam int PADDLEHEIGHT = 50;
    localparam int BALLR        = 10;
    localparam int BALLSPEED    = 4;
    localparam int PADDLESPEED  = 6;
    localparam int SERVE_FRAMES = 60;
    localparam int SOUND_FRAMES = 8;
    localparam int WIN_SCORE    = 9;

    typedef enum logic [1:0] {SERVE, PLAY, POINT, GAMEOVER} state_t;

    localparam logic [3:0] SND_MISS   = 4'b1000;
    localparam logic [3:0] SND_PADDLE = 4'b0100;
    localparam logic [3:0] SND_WALL   = 4'b0010;
    localparam logic [3:0] SND_END    = 4'b0001;

    // Derived geometry
    localparam logic [9:0] PADDLE_CENTRE = 10'((SCREENHEIGHT - PADDLEHEIGHT) / 2);
    localparam logic [9:0] PADDLE_MAX    = 10'(SCREENHEIGHT - PADDLEHEIGHT);
    localparam logic [9:0] BALL_X0       = 10'(SCREENWIDTH / 2);
    localparam logic [9:0] BALL_Y0       = 10'(SCREENHEIGHT / 2);
    localparam logic [9:0] BALL_TOP      = 10'(BALLR);
    localparam logic [9:0] BALL_BOT      = 10'(SCREENHEIGHT - 1 - BALLR);
    localparam logic [9:0] BALL_LEFT     = 10'(PADDLEWIDTH + BALLR);
    localparam logic [9:0] BALL_RIGHT    = 10'(SCREENWIDTH - 1 - PADDLEWIDTH - BALLR);
    localparam logic [9:0] BALL_STEP     = 10'(BALLSPEED);

    localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);
    localparam logic [3:0] SOUND_HOLD = 4'(SOUND_FRAMES);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    localparam logic signed [10:0] HIT_ABOVE = 11'(BALLR);
    localparam logic signed [10:0] HIT_BELOW = 11'(PADDLEHEIGHT + BALLR);

    // Ball centre y within reach of a paddle whose top is at p (signed so p-BALLR may go negative)
    function automatic logic in_window(input logic [9:0] y, input logic [9:0] p);
        logic signed [10:0] ys;
        logic signed [10:0] ps;
        ys = signed'({1'b0, y});
        ps = signed'({1'b0, p});
        return (ys >= ps - HIT_ABOVE) && (ys < ps + HIT_BELOW);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == WIN) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - one paddle position register with per-frame move and clamp
// Ports: clk, reset (async, active-high), frame_tick (advance strobe), enable (move allowed),
//        recentre (load centre position on frame_tick), up/dn (buttons), pos (paddle top y).
module paddle_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       recentre,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] pos
);

    logic [10:0] sum;
    logic [10:0] dif;
    logic [9:0]  nxt;

    // 11-bit arithmetic: a borrow in dif or an overflow past PADDLE_MAX in sum is clamped
    always_comb begin
        sum = {1'b0, pos} + 11'(PADDLESPEED);
        dif = {1'b0, pos} - 11'(PADDLESPEED);
        nxt = pos;
        if (up && !dn) begin
            nxt = dif[10] ? 10'd0 : dif[9:0];
        end else if (dn && !up) begin
            nxt = (sum > {1'b0, PADDLE_MAX}) ? PADDLE_MAX : sum[9:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= PADDLE_CENTRE;
        end else if (frame_tick) begin
            if (recentre) begin
                pos <= PADDLE_CENTRE;
            end else if (enable) begin
                pos <= nxt;
            end
        end
    end

endmodule

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - per-frame pong game state: paddles, ball physics, score, sound, sequencing
// Ports: clk, reset (async, active-high), frame_tick (one pulse per frame), start (restart from game over),
//        p1_up/p1_dn/p2_up/p2_dn (buttons), paddle1/paddle2 (paddle top y), ballx/bally (ball centre),
//        score1/score2, sound_sel (one-hot tone, 0 = silent), game_over.
module pong_engine
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [9:0] paddle1,
    output logic [9:0] paddle2,
    output logic [9:0] ballx,
    output logic [9:0] bally,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] sound_sel,
    output logic       game_over
);

    state_t     state, state_n;
    logic [5:0] cnt, cnt_n;
    logic [9:0] ballx_n, bally_n;
    logic       dx_right, dx_right_n;
    logic       dy_down, dy_down_n;
    logic [3:0] score1_n, score2_n;
    logic [3:0] sound_n;
    logic [3:0] snd_cnt, snd_cnt_n;
    logic       ev_miss, ev_paddle, ev_wall, ev_end;
    logic [10:0] by_up, by_dn, bx_up, bx_dn;

    logic paddle_en;
    logic restart;

    assign paddle_en = (state != GAMEOVER);
    assign restart   = (state == GAMEOVER) && start;
    assign game_over = (state == GAMEOVER);

    paddle_ctrl u_paddle1 (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .enable     (paddle_en),
        .recentre   (restart),
        .up         (p1_up),
        .dn         (p1_dn),
        .pos        (paddle1)
    );

    paddle_ctrl u_paddle2 (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .enable     (paddle_en),
        .recentre   (restart),
        .up         (p2_up),
        .dn         (p2_dn),
        .pos        (paddle2)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        ballx_n    = ballx;
        bally_n    = bally;
        dx_right_n = dx_right;
        dy_down_n  = dy_down;
        score1_n   = score1;
        score2_n   = score2;
        ev_miss    = 1'b0;
        ev_paddle  = 1'b0;
        ev_wall    = 1'b0;
        ev_end     = 1'b0;
        by_up      = {1'b0, bally} - {1'b0, BALL_STEP};
        by_dn      = {1'b0, bally} + {1'b0, BALL_STEP};
        bx_up      = {1'b0, ballx} - {1'b0, BALL_STEP};
        bx_dn      = {1'b0, ballx} + {1'b0, BALL_STEP};

        case (state)
            SERVE: begin
                ballx_n = BALL_X0;
                bally_n = BALL_Y0;
                if (cnt == SERVE_LAST) begin
                    cnt_n   = 6'd0;
                    state_n = PLAY;
                end else begin
                    cnt_n = cnt + 6'd1;
                end
            end
            PLAY: begin
                // Vertical: a step that would cross a wall lands exactly on the wall limit
                if (!dy_down) begin
                    if (by_up[10] || (by_up[9:0] < BALL_TOP)) begin
                        bally_n   = BALL_TOP;
                        dy_down_n = 1'b1;
                        ev_wall   = 1'b1;
                    end else begin
                        bally_n = by_up[9:0];
                    end
                end else begin
                    if (by_dn > {1'b0, BALL_BOT}) begin
                        bally_n   = BALL_BOT;
                        dy_down_n = 1'b0;
                        ev_wall   = 1'b1;
                    end else begin
                        bally_n = by_dn[9:0];
                    end
                end
                // Horizontal: on a miss x stays put and dx is left pointing at the conceding player,
                // which is the serve direction for the next rally
                if (!dx_right) begin
                    if (bx_up[10] || (bx_up[9:0] < BALL_LEFT)) begin
                        if (in_window(bally, paddle1)) begin
                            ballx_n    = BALL_LEFT;
                            dx_right_n = 1'b1;
                            ev_paddle  = 1'b1;
                        end else begin
                            score2_n = sat_inc(score2);
                            state_n  = POINT;
                            cnt_n    = 6'd0;
                            ev_miss  = 1'b1;
                        end
                    end else begin
                        ballx_n = bx_up[9:0];
                    end
                end else begin
                    if (bx_dn > {1'b0, BALL_RIGHT}) begin
                        if (in_window(bally, paddle2)) begin
                            ballx_n    = BALL_RIGHT;
                            dx_right_n = 1'b0;
                            ev_paddle  = 1'b1;
                        end else begin
                            score1_n = sat_inc(score1);
                            state_n  = POINT;
                            cnt_n    = 6'd0;
                            ev_miss  = 1'b1;
                        end
                    end else begin
                        ballx_n = bx_dn[9:0];
                    end
                end
            end
            POINT: begin
                if (cnt == SERVE_LAST) begin
                    cnt_n = 6'd0;
                    if ((score1 == WIN) || (score2 == WIN)) begin
                        state_n = GAMEOVER;
                        ev_end  = 1'b1;
                    end else begin
                        state_n = SERVE;
                        ballx_n = BALL_X0;
                        bally_n = BALL_Y0;
                    end
                end else begin
                    cnt_n = cnt + 6'd1;
                end
            end
            GAMEOVER: begin
                if (start) begin
                    score1_n = 4'd0;
                    score2_n = 4'd0;
                    ballx_n  = BALL_X0;
                    bally_n  = BALL_Y0;
                    cnt_n    = 6'd0;
                    state_n  = SERVE;
                end
            end
            default: state_n = SERVE;
        endcase

        // Sound: newest event wins and restarts the hold; otherwise count the hold down
        sound_n   = sound_sel;
        snd_cnt_n = snd_cnt;
        if (ev_miss || ev_paddle || ev_wall || ev_end) begin
            snd_cnt_n = SOUND_HOLD;
            if (ev_miss)        sound_n = SND_MISS;
            else if (ev_paddle) sound_n = SND_PADDLE;
            else if (ev_wall)   sound_n = SND_WALL;
            else                sound_n = SND_END;
        end else if (snd_cnt != 4'd0) begin
            snd_cnt_n = snd_cnt - 4'd1;
            if (snd_cnt == 4'd1) sound_n = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SERVE;
            cnt       <= 6'd0;
            ballx     <= BALL_X0;
            bally     <= BALL_Y0;
            dx_right  <= 1'b1;
            dy_down   <= 1'b1;
            score1    <= 4'd0;
            score2    <= 4'd0;
            sound_sel <= 4'd0;
            snd_cnt   <= 4'd0;
        end else if (frame_tick) begin
            state     <= state_n;
            cnt       <= cnt_n;
            ballx     <= ballx_n;
            bally     <= bally_n;
            dx_right  <= dx_right_n;
            dy_down   <= dy_down_n;
            score1    <= score1_n;
            score2    <= score2_n;
            sound_sel <= sound_n;
            snd_cnt   <= snd_cnt_n;
        end
    end

endmodule
